// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the CPU
// load/store unit (port 0) and the DMA/debug loader (port 1).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [15:0]       stall_cnt0,
  output logic [15:0]       stall_cnt1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic              prio;
  logic              locked;
  logic              lock_owner;
  logic [1:0]        eff_valid;
  logic              grant_any;
  logic              grant_port;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  // The memory is clearing itself while reset is high, so nothing may be granted then.
  always_comb begin
    eff_valid  = reset ? 2'b00 : req_valid;
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if (locked && eff_valid[lock_owner]) begin
      grant_any  = 1'b1;
      grant_port = lock_owner;
    end else begin
      case (eff_valid)
        2'b01: begin
          grant_any  = 1'b1;
          grant_port = 1'b0;
        end
        2'b10: begin
          grant_any  = 1'b1;
          grant_port = 1'b1;
        end
        2'b11: begin
          grant_any  = 1'b1;
          grant_port = prio;
        end
        default: begin
          grant_any  = 1'b0;
          grant_port = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    grant_we    = grant_port ? req_we[1]  : req_we[0];
    grant_addr  = grant_port ? req_addr1  : req_addr0;
    grant_wdata = grant_port ? req_wdata1 : req_wdata0;
  end

  always_comb begin
    req_ready        = 2'b00;
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = '0;
    if (grant_any) begin
      req_ready[grant_port] = 1'b1;
      mem_address           = grant_addr;
      if (grant_we) begin
        mem_write_enable = 1'b1;
        mem_write_data   = grant_wdata;
      end else begin
        mem_read_enable = 1'b1;
      end
    end
  end

  // Every accepted transfer hands priority to the other port, lock-held ones included.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio       <= 1'b0;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 2'b00;
      if (grant_any) begin
        prio       <= ~grant_port;
        locked     <= req_lock[grant_port];
        lock_owner <= grant_port;
        if (!grant_we) begin
          rsp_valid[grant_port] <= 1'b1;
          rsp_rdata             <= mem_read_data;
        end
      end else if (locked && !req_valid[lock_owner]) begin
        locked <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt0 <= 16'h0000;
      stall_cnt1 <= 16'h0000;
    end else begin
      if (req_valid[0] && !req_ready[0] && (stall_cnt0 != 16'hFFFF))
        stall_cnt0 <= stall_cnt0 + 16'd1;
      if (req_valid[1] && !req_ready[1] && (stall_cnt1 != 16'hFFFF))
        stall_cnt1 <= stall_cnt1 + 16'd1;
    end
  end

endmodule
